// File: rtl/param_register_file.sv
// -----------------------------------------------------------------------------
// param_register_file
//
// Purpose:
//   Parametrised register file with NUM_REGS = 2**ADDR_WIDTH words of
//   DATA_WIDTH bits. It has one synchronous write port and two independently
//   enabled read ports. Read data and valid flags are registered, so a read
//   issued on one edge is presented after that edge. A read that hits the
//   address being written on the same edge returns the new write data
//   (write-first bypass). When ZERO_REG0 is set, register 0 is hard-wired to
//   zero: writes to it are dropped and reads of it return zero.
//
// Parameters:
//   DATA_WIDTH  bits per register
//   ADDR_WIDTH  address bits (NUM_REGS = 2**ADDR_WIDTH)
//   ZERO_REG0   1: register 0 reads as zero and ignores writes
//
// Ports:
//   clk      in   1           rising-edge clock
//   reset_n  in   1           asynchronous active-low reset
//   we       in   1           write enable
//   wAddr    in   ADDR_WIDTH  write address
//   wData    in   DATA_WIDTH  write data
//   re0      in   1           read enable, port 0
//   rAddr0   in   ADDR_WIDTH  read address, port 0
//   rData0   out  DATA_WIDTH  registered read data, port 0
//   rValid0  out  1           rData0 holds a read issued last cycle
//   re1      in   1           read enable, port 1
//   rAddr1   in   ADDR_WIDTH  read address, port 1
//   rData1   out  DATA_WIDTH  registered read data, port 1
//   rValid1  out  1           rData1 holds a read issued last cycle
// -----------------------------------------------------------------------------
module param_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG0  = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wAddr,
    input  logic [DATA_WIDTH-1:0] wData,
    input  logic                  re0,
    input  logic [ADDR_WIDTH-1:0] rAddr0,
    output logic [DATA_WIDTH-1:0] rData0,
    output logic                  rValid0,
    input  logic                  re1,
    input  logic [ADDR_WIDTH-1:0] rAddr1,
    output logic [DATA_WIDTH-1:0] rData1,
    output logic                  rValid1
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  write_ok;
    logic [DATA_WIDTH-1:0] rd0_next;
    logic [DATA_WIDTH-1:0] rd1_next;

    // Writes to register 0 are discarded when it is the hard-wired zero register.
    assign write_ok = we && !((ZERO_REG0 != 0) && (wAddr == '0));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[wAddr] <= wData;
        end
    end

    // Read-value selection: the zero register wins over everything, then a
    // same-edge write to the same address is forwarded so readers see new data.
    always_comb begin
        rd0_next = regs[rAddr0];
        if ((ZERO_REG0 != 0) && (rAddr0 == '0)) begin
            rd0_next = '0;
        end else if (we && (rAddr0 == wAddr)) begin
            rd0_next = wData;
        end
    end

    always_comb begin
        rd1_next = regs[rAddr1];
        if ((ZERO_REG0 != 0) && (rAddr1 == '0)) begin
            rd1_next = '0;
        end else if (we && (rAddr1 == wAddr)) begin
            rd1_next = wData;
        end
    end

    // Output registers: data is held when the port is idle, valid only
    // reflects whether a read was issued on the previous edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rData0  <= '0;
            rValid0 <= 1'b0;
            rData1  <= '0;
            rValid1 <= 1'b0;
        end else begin
            rValid0 <= re0;
            rValid1 <= re1;
            if (re0) begin
                rData0 <= rd0_next;
            end
            if (re1) begin
                rData1 <= rd1_next;
            end
        end
    end

endmodule

// File: tb/tb_param_register_file.sv
// -----------------------------------------------------------------------------
// tb_param_register_file
//
// Purpose:
//   Directed self-checking bench for param_register_file. Two instances share
//   the same stimulus: dut with ZERO_REG0=0 and dut_z with ZERO_REG0=1.
//   Inputs change 1ns after a rising edge; outputs are sampled at that point,
//   i.e. after the edge has settled and well away from the next edge.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_param_register_file;

    logic        clk;
    logic        reset_n;
    logic        we;
    logic [2:0]  wAddr;
    logic [31:0] wData;
    logic        re0;
    logic [2:0]  rAddr0;
    logic        re1;
    logic [2:0]  rAddr1;

    logic [31:0] rData0, rData1, zData0, zData1;
    logic        rValid0, rValid1, zValid0, zValid1;

    int checks = 0;
    int errors = 0;

    param_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .ZERO_REG0(0)) dut (
        .clk(clk), .reset_n(reset_n),
        .we(we), .wAddr(wAddr), .wData(wData),
        .re0(re0), .rAddr0(rAddr0), .rData0(rData0), .rValid0(rValid0),
        .re1(re1), .rAddr1(rAddr1), .rData1(rData1), .rValid1(rValid1)
    );

    param_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .ZERO_REG0(1)) dut_z (
        .clk(clk), .reset_n(reset_n),
        .we(we), .wAddr(wAddr), .wData(wData),
        .re0(re0), .rAddr0(rAddr0), .rData0(zData0), .rValid0(zValid0),
        .re1(re1), .rAddr1(rAddr1), .rData1(zData1), .rValid1(zValid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1ns past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; wAddr = '0; wData = '0;
        re0 = 1'b0; rAddr0 = '0;
        re1 = 1'b0; rAddr1 = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        step();
        step();
        #4;
        reset_n = 1'b1;
        checks++; if (rData0 !== 32'h0) begin errors++; $display("[TB] FAIL reset_rData0 got %h want %h", rData0, 32'h0); end
        checks++; if (rData1 !== 32'h0) begin errors++; $display("[TB] FAIL reset_rData1 got %h want %h", rData1, 32'h0); end
        checks++; if (rValid0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_rValid0 got %b want 0", rValid0); end
        checks++; if (rValid1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_rValid1 got %b want 0", rValid1); end
        step();
        for (int i = 0; i < 8; i++) begin
            re0 = 1'b1; rAddr0 = 3'(i);
            re1 = 1'b1; rAddr1 = 3'(7 - i);
            step();
            checks++; if (rData0 !== 32'h0) begin errors++; $display("[TB] FAIL reset_read0[%0d] got %h want %h", i, rData0, 32'h0); end
            checks++; if (rData1 !== 32'h0) begin errors++; $display("[TB] FAIL reset_read1[%0d] got %h want %h", 7 - i, rData1, 32'h0); end
            checks++; if (rValid0 !== 1'b1) begin errors++; $display("[TB] FAIL reset_valid0[%0d] got %b want 1", i, rValid0); end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_fill_readback();
        logic [31:0] exp0, exp1;
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; wAddr = 3'(i); wData = 32'h1 << (4 * i);
            step();
        end
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            re0 = 1'b1; rAddr0 = 3'(i);
            re1 = 1'b1; rAddr1 = 3'(7 - i);
            exp0 = 32'h1 << (4 * i);
            exp1 = 32'h1 << (4 * (7 - i));
            step();
            checks++; if (rData0 !== exp0) begin errors++; $display("[TB] FAIL fill_rData0[%0d] got %h want %h", i, rData0, exp0); end
            checks++; if (rData1 !== exp1) begin errors++; $display("[TB] FAIL fill_rData1[%0d] got %h want %h", 7 - i, rData1, exp1); end
            checks++; if (rValid0 !== 1'b1) begin errors++; $display("[TB] FAIL fill_rValid0[%0d] got %b want 1", i, rValid0); end
            checks++; if (rValid1 !== 1'b1) begin errors++; $display("[TB] FAIL fill_rValid1[%0d] got %b want 1", i, rValid1); end
        end
        // Zero-register build keeps reg 0 at zero but stores the rest normally.
        re0 = 1'b1; rAddr0 = 3'd0;
        re1 = 1'b1; rAddr1 = 3'd6;
        step();
        checks++; if (zData0 !== 32'h0) begin errors++; $display("[TB] FAIL fill_zero_reg0 got %h want %h", zData0, 32'h0); end
        checks++; if (zData1 !== 32'h0100_0000) begin errors++; $display("[TB] FAIL fill_zero_reg6 got %h want %h", zData1, 32'h0100_0000); end
        idle_inputs();
        step();
        checks++; if (rValid0 !== 1'b0) begin errors++; $display("[TB] FAIL fill_idle_valid0 got %b want 0", rValid0); end
        checks++; if (rValid1 !== 1'b0) begin errors++; $display("[TB] FAIL fill_idle_valid1 got %b want 0", rValid1); end
    endtask

    task automatic test_bypass();
        we = 1'b1; wAddr = 3'd3; wData = 32'hAAAA_AAAA;
        step();
        we = 1'b1; wAddr = 3'd3; wData = 32'h5555_5555;
        re0 = 1'b1; rAddr0 = 3'd3;
        re1 = 1'b1; rAddr1 = 3'd4;
        step();
        checks++; if (rData0 !== 32'h5555_5555) begin errors++; $display("[TB] FAIL bypass_rData0 got %h want %h", rData0, 32'h5555_5555); end
        checks++; if (rData1 !== 32'h0001_0000) begin errors++; $display("[TB] FAIL bypass_port1 got %h want %h", rData1, 32'h0001_0000); end
        checks++; if (zData0 !== 32'h5555_5555) begin errors++; $display("[TB] FAIL bypass_zero_build got %h want %h", zData0, 32'h5555_5555); end
        idle_inputs();
        re1 = 1'b1; rAddr1 = 3'd3;
        step();
        checks++; if (rData1 !== 32'h5555_5555) begin errors++; $display("[TB] FAIL bypass_stored got %h want %h", rData1, 32'h5555_5555); end
        checks++; if (rValid0 !== 1'b0) begin errors++; $display("[TB] FAIL bypass_valid0_drop got %b want 0", rValid0); end
        idle_inputs();
        step();
    endtask

    task automatic test_hold();
        re0 = 1'b1; rAddr0 = 3'd2;
        step();
        checks++; if (rData0 !== 32'h0000_0100) begin errors++; $display("[TB] FAIL hold_first got %h want %h", rData0, 32'h0000_0100); end
        checks++; if (rValid0 !== 1'b1) begin errors++; $display("[TB] FAIL hold_first_valid got %b want 1", rValid0); end
        re0 = 1'b0;
        we = 1'b1; wAddr = 3'd2; wData = 32'h1234_5678;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (rData0 !== 32'h0000_0100) begin errors++; $display("[TB] FAIL hold_data[%0d] got %h want %h", c, rData0, 32'h0000_0100); end
            checks++; if (rValid0 !== 1'b0) begin errors++; $display("[TB] FAIL hold_valid[%0d] got %b want 0", c, rValid0); end
        end
        idle_inputs();
        re0 = 1'b1; rAddr0 = 3'd2;
        step();
        checks++; if (rData0 !== 32'h1234_5678) begin errors++; $display("[TB] FAIL hold_after got %h want %h", rData0, 32'h1234_5678); end
        idle_inputs();
        step();
    endtask

    task automatic test_zero_reg0();
        we = 1'b1; wAddr = 3'd0; wData = 32'hFFFF_FFFF;
        re0 = 1'b1; rAddr0 = 3'd0;
        re1 = 1'b1; rAddr1 = 3'd0;
        step();
        checks++; if (zData0 !== 32'h0) begin errors++; $display("[TB] FAIL zero_same_edge0 got %h want %h", zData0, 32'h0); end
        checks++; if (zData1 !== 32'h0) begin errors++; $display("[TB] FAIL zero_same_edge1 got %h want %h", zData1, 32'h0); end
        checks++; if (zValid0 !== 1'b1) begin errors++; $display("[TB] FAIL zero_valid0 got %b want 1", zValid0); end
        checks++; if (rData0 !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL plain_reg0_bypass got %h want %h", rData0, 32'hFFFF_FFFF); end
        we = 1'b0;
        step();
        checks++; if (zData0 !== 32'h0) begin errors++; $display("[TB] FAIL zero_next_cycle got %h want %h", zData0, 32'h0); end
        checks++; if (rData1 !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL plain_reg0_stored got %h want %h", rData1, 32'hFFFF_FFFF); end
        idle_inputs();
        step();
    endtask

    task automatic test_async_reset();
        we = 1'b1; wAddr = 3'd5; wData = 32'hCAFE_BABE;
        step();
        we = 1'b0;
        re0 = 1'b1; rAddr0 = 3'd5;
        re1 = 1'b1; rAddr1 = 3'd5;
        step();
        checks++; if (rData0 !== 32'hCAFE_BABE) begin errors++; $display("[TB] FAIL areset_preload got %h want %h", rData0, 32'hCAFE_BABE); end
        // Leave a write and reads pending, then pull reset between edges.
        we = 1'b1; wAddr = 3'd6; wData = 32'hDEAD_BEEF;
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (rData0 !== 32'h0) begin errors++; $display("[TB] FAIL areset_rData0 got %h want %h", rData0, 32'h0); end
        checks++; if (rData1 !== 32'h0) begin errors++; $display("[TB] FAIL areset_rData1 got %h want %h", rData1, 32'h0); end
        checks++; if (rValid0 !== 1'b0) begin errors++; $display("[TB] FAIL areset_rValid0 got %b want 0", rValid0); end
        checks++; if (rValid1 !== 1'b0) begin errors++; $display("[TB] FAIL areset_rValid1 got %b want 0", rValid1); end
        idle_inputs();
        step();
        #4;
        reset_n = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            re0 = 1'b1; rAddr0 = 3'(i);
            re1 = 1'b1; rAddr1 = 3'(i);
            step();
            checks++; if (rData0 !== 32'h0) begin errors++; $display("[TB] FAIL areset_read[%0d] got %h want %h", i, rData0, 32'h0); end
            checks++; if (zData1 !== 32'h0) begin errors++; $display("[TB] FAIL areset_zread[%0d] got %h want %h", i, zData1, 32'h0); end
        end
        idle_inputs();
        step();
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        test_reset();
        test_fill_readback();
        test_bypass();
        test_hold();
        test_zero_reg0();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
